// File: rtl/sdpb_capture_ctrl_if.sv
// Sample-in / sample-out stream bundle for the capture buffer controller.
interface sdpb_capture_ctrl_if;
    logic        s_valid;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;

    // Controller side: consumes the sample stream, sources the readout stream.
    modport master (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output m_valid,
        output m_data,
        output m_last
    );

    // Environment side: sample source plus readout consumer.
    modport slave (
        output s_valid,
        output s_data,
        output m_ready,
        input  m_valid,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/sdpb_capture_ctrl.sv
// Capture buffer sequencer: packs 16-bit samples four per 64-bit RAM word,
// fills a 128-sample buffer, then drains it as a valid/ready 16-bit stream.
module sdpb_capture_ctrl (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    sdpb_capture_ctrl_if.master        strm,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf,
    output logic                       ram_cea,
    output logic [4:0]                 ram_ada,
    output logic [63:0]                ram_din,
    output logic                       ram_ceb,
    output logic [6:0]                 ram_adb,
    output logic                       ram_oce,
    output logic                       ram_reseta,
    output logic                       ram_resetb,
    input  logic [15:0]                ram_dout
);

    localparam int unsigned SAMPLES  = 128;
    localparam int unsigned ADA_W    = 5;
    localparam int unsigned ADB_W    = 7;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned LANES    = 4;
    localparam int unsigned WORD_W   = SAMPLE_W * LANES;
    localparam int unsigned WORDS    = SAMPLES / LANES;
    localparam int unsigned PTR_W    = ADB_W + 1;
    localparam int unsigned PACK_W   = SAMPLE_W * (LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e              state_q,   state_d;
    logic [1:0]          lane_q,    lane_d;
    logic [ADA_W-1:0]    wr_word_q, wr_word_d;
    logic [PACK_W-1:0]   pack_q,    pack_d;
    logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [ADB_W-1:0]    out_idx_q, out_idx_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q,  m_last_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                ovf_q,     ovf_d;
    logic                ram_cea_q, ram_cea_d;
    logic [ADA_W-1:0]    ram_ada_q, ram_ada_d;
    logic [WORD_W-1:0]   ram_din_q, ram_din_d;
    logic                issue_c;
    logic                hs_c;

    // State register and all output flops; synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lane_q    <= '0;
            wr_word_q <= '0;
            pack_q    <= '0;
            rd_ptr_q  <= '0;
            out_idx_q <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ram_cea_q <= 1'b0;
            ram_ada_q <= '0;
            ram_din_q <= '0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            wr_word_q <= wr_word_d;
            pack_q    <= pack_d;
            rd_ptr_q  <= rd_ptr_d;
            out_idx_q <= out_idx_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            ram_cea_q <= ram_cea_d;
            ram_ada_q <= ram_ada_d;
            ram_din_q <= ram_din_d;
        end
    end

    // Next-state, packing, drain issue and output computation.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        wr_word_d = wr_word_q;
        pack_d    = pack_q;
        rd_ptr_d  = rd_ptr_q;
        out_idx_d = out_idx_q;
        m_valid_d = m_valid_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        ram_cea_d = 1'b0;
        ram_ada_d = ram_ada_q;
        ram_din_d = ram_din_q;
        issue_c   = 1'b0;
        hs_c      = m_valid_q && strm.m_ready;

        // Samples outside FILL are dropped and flagged.
        if (strm.s_valid && (state_q != ST_FILL)) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FILL;
                    lane_d    = '0;
                    wr_word_d = '0;
                    pack_d    = '0;
                    rd_ptr_d  = '0;
                    out_idx_d = '0;
                    ovf_d     = 1'b0;
                end
            end

            ST_FILL: begin
                if (strm.s_valid) begin
                    if (lane_q == 2'd3) begin
                        // Fourth sample completes the word; sample 0 sits in the LSBs.
                        ram_din_d = {strm.s_data, pack_q};
                        ram_ada_d = wr_word_q;
                        ram_cea_d = 1'b1;
                        wr_word_d = wr_word_q + 5'd1;
                        lane_d    = 2'd0;
                        if (wr_word_q == ADA_W'(WORDS - 1)) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        case (lane_q)
                            2'd0:    pack_d[15:0]  = strm.s_data;
                            2'd1:    pack_d[31:16] = strm.s_data;
                            default: pack_d[47:32] = strm.s_data;
                        endcase
                        lane_d = lane_q + 2'd1;
                    end
                end
            end

            ST_DRAIN: begin
                // Read only when the output slot is free or being emptied this cycle.
                issue_c = (rd_ptr_q < PTR_W'(SAMPLES)) && (!m_valid_q || strm.m_ready);
                if (issue_c) begin
                    rd_ptr_d = rd_ptr_q + 8'd1;
                end
                m_valid_d = issue_c ? 1'b1 : (m_valid_q && !strm.m_ready);
                if (hs_c) begin
                    out_idx_d = out_idx_q + 7'd1;
                    if (out_idx_q == ADB_W'(SAMPLES - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        m_last_d = m_valid_d && (out_idx_d == ADB_W'(SAMPLES - 1));
        busy_d   = (state_d != ST_IDLE);
    end

    // Output wiring; read enable and read data bypass the flops.
    assign strm.m_valid = m_valid_q;
    assign strm.m_last  = m_last_q;
    assign strm.m_data  = ram_dout;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ovf          = ovf_q;
    assign ram_cea      = ram_cea_q;
    assign ram_ada      = ram_ada_q;
    assign ram_din      = ram_din_q;
    assign ram_ceb      = issue_c;
    assign ram_adb      = rd_ptr_q[ADB_W-1:0];
    assign ram_oce      = 1'b1;
    assign ram_reseta   = reset;
    assign ram_resetb   = reset;

endmodule

// File: tb/tb_sdpb_capture_ctrl.sv
// Randomized bench for sdpb_capture_ctrl with a queue-based reference model
// and a behavioural 32x64 / 128x16 RAM.
module tb_sdpb_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, ovf;
    logic        ram_cea, ram_ceb, ram_oce, ram_reseta, ram_resetb;
    logic [4:0]  ram_ada;
    logic [63:0] ram_din;
    logic [6:0]  ram_adb;
    logic [15:0] ram_dout;

    sdpb_capture_ctrl_if bus ();

    sdpb_capture_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .strm       (bus),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .ram_cea    (ram_cea),
        .ram_ada    (ram_ada),
        .ram_din    (ram_din),
        .ram_ceb    (ram_ceb),
        .ram_adb    (ram_adb),
        .ram_oce    (ram_oce),
        .ram_reseta (ram_reseta),
        .ram_resetb (ram_resetb),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: 64-bit write port, 16-bit read port, one-cycle read latency.
    logic [63:0] mem [32];
    always @(posedge clk) begin
        if (ram_cea) mem[ram_ada] <= ram_din;
        if (ram_ceb) begin
            case (ram_adb[1:0])
                2'd0:    ram_dout <= mem[ram_adb[6:2]][15:0];
                2'd1:    ram_dout <= mem[ram_adb[6:2]][31:16];
                2'd2:    ram_dout <= mem[ram_adb[6:2]][47:32];
                default: ram_dout <= mem[ram_adb[6:2]][63:48];
            endcase
        end
    end

    // Reference model: captured samples kept in a queue, expectations per edge.
    int          mode = 0;          // 0 idle, 1 filling, 2 draining
    logic [15:0] cap [$];
    logic        exp_wr = 1'b0;
    logic [4:0]  exp_ada = '0;
    logic [63:0] exp_din = '0;
    logic        exp_ovf = 1'b0;
    logic        exp_done = 1'b0;
    logic        mv = 1'b0;
    int          issued = 0;
    int          hs = 0;
    int          mdl_n;
    logic        mdl_hs, mdl_iss;

    always @(posedge clk) begin
        if (reset) begin
            mode = 0; mv = 1'b0; exp_wr = 1'b0; exp_done = 1'b0;
            exp_ovf = 1'b0; issued = 0; hs = 0;
        end else begin
            exp_wr   = 1'b0;
            exp_done = 1'b0;
            if (mode == 0) begin
                if (bus.s_valid) exp_ovf = 1'b1;
                if (start) begin
                    mode = 1; cap.delete(); exp_ovf = 1'b0; issued = 0; hs = 0;
                end
            end else if (mode == 1) begin
                if (bus.s_valid) begin
                    cap.push_back(bus.s_data);
                    mdl_n = cap.size();
                    if (mdl_n % 4 == 0) begin
                        exp_wr  = 1'b1;
                        exp_ada = 5'(mdl_n / 4 - 1);
                        exp_din = {cap[mdl_n-1], cap[mdl_n-2], cap[mdl_n-3], cap[mdl_n-4]};
                        if (mdl_n == 128) mode = 2;
                    end
                end
            end else begin
                if (bus.s_valid) exp_ovf = 1'b1;
                mdl_hs  = mv && bus.m_ready;
                mdl_iss = (issued < 128) && (!mv || bus.m_ready);
                if (mdl_hs) hs++;
                if (mdl_iss) issued++;
                mv = mdl_iss || (mv && !bus.m_ready);
                if (hs == 128) begin
                    mode = 0; exp_done = 1'b1;
                end
            end
        end
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] wr_log [32];
    logic [15:0] out_q [$];
    int          last_pos = -1;
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic monitor();
        logic exp_ceb;
        chk("busy", 64'(busy), 64'(mode != 0));
        chk("ovf", 64'(ovf), 64'(exp_ovf));
        chk("done", 64'(done), 64'(exp_done));
        chk("ram_cea", 64'(ram_cea), 64'(exp_wr));
        if (exp_wr) begin
            chk("ram_ada", 64'(ram_ada), 64'(exp_ada));
            chk("ram_din", ram_din, exp_din);
        end
        chk("m_valid", 64'(bus.m_valid), 64'(mv));
        if (mv) begin
            chk("m_data", 64'(bus.m_data), 64'(cap[hs]));
            chk("m_last", 64'(bus.m_last), 64'(hs == 127));
        end else begin
            chk("m_last_idle", 64'(bus.m_last), 64'(1'b0));
        end
        exp_ceb = (mode == 2) && (issued < 128) && (!mv || bus.m_ready);
        chk("ram_ceb", 64'(ram_ceb), 64'(exp_ceb));
        if (exp_ceb) chk("ram_adb", 64'(ram_adb), 64'(issued[6:0]));
        chk("ram_oce", 64'(ram_oce), 64'(1'b1));
        chk("ram_resets", 64'({ram_reseta, ram_resetb}), 64'({reset, reset}));
        if (prev_stall) chk("stall_hold", 64'(bus.m_data), 64'(prev_data));
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        if (ram_cea) wr_log[ram_ada] = ram_din;
        if (bus.m_valid && bus.m_ready) begin
            out_q.push_back(bus.m_data);
            if (bus.m_last) last_pos = out_q.size();
        end
        if (done) done_cnt++;
    endtask

    // Apply inputs for the coming edge, then compare the current outputs.
    task automatic cyc(input logic sv, input logic [15:0] sd, input logic st, input logic rdy);
        @(negedge clk);
        bus.s_valid = sv;
        bus.s_data  = sd;
        start       = st;
        bus.m_ready = rdy;
        #1;
        monitor();
    endtask

    task automatic feed(input logic [15:0] base, input int gap, input int n, input int start_at);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, base + 16'(i), 1'(i == start_at), 1'b1);
            for (int g = 0; g < gap; g++) cyc(1'b0, 16'h0, 1'b0, 1'b1);
        end
    endtask

    task automatic drain(input bit rand_rdy, input bit junk, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            cyc(junk, 16'($urandom), 1'b0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_seq(input string nm, input int base_idx, input logic [15:0] base);
        int errs = 0;
        if (out_q.size() < base_idx + 128) errs = 1000;
        else for (int i = 0; i < 128; i++) if (out_q[base_idx + i] !== base + 16'(i)) errs++;
        chk(nm, 64'(errs), 64'(0));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_outs"}, 64'({busy, done, ovf, bus.m_valid, bus.m_last, ram_cea, ram_ceb}), 64'(0));
        chk({nm, "_ada"}, 64'(ram_ada), 64'(0));
        chk({nm, "_din"}, ram_din, 64'(0));
        chk({nm, "_adb"}, 64'(ram_adb), 64'(0));
    endtask

    initial begin
        bit ok;
        int base_idx;
        int dc;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        // Reset state.
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Continuous ramp with m_ready held high.
        base_idx = out_q.size(); dc = done_cnt;
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        feed(16'h0000, 0, 128, -1);
        drain(1'b0, 1'b0, ok);
        chk("ramp_done_seen", 64'(ok), 64'(1));
        chk("ramp_word0", wr_log[0], 64'h0003_0002_0001_0000);
        chk("ramp_word31", wr_log[31], 64'h007F_007E_007D_007C);
        chk_seq("ramp_seq", base_idx, 16'h0000);
        chk("ramp_last_pos", 64'(last_pos), 64'(base_idx + 128));
        chk("ramp_done_cnt", 64'(done_cnt - dc), 64'(1));
        chk("ramp_ovf", 64'(ovf), 64'(0));

        // Random backpressure.
        base_idx = out_q.size(); dc = done_cnt;
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        feed(16'h4000, 0, 128, -1);
        drain(1'b1, 1'b0, ok);
        chk("bp_done_seen", 64'(ok), 64'(1));
        chk_seq("bp_seq", base_idx, 16'h4000);
        chk("bp_done_cnt", 64'(done_cnt - dc), 64'(1));

        // Sparse input, one sample every third cycle.
        base_idx = out_q.size();
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        feed(16'h8000, 2, 128, -1);
        drain(1'b0, 1'b0, ok);
        chk("sparse_done_seen", 64'(ok), 64'(1));
        chk("sparse_word1", wr_log[1], 64'h8007_8006_8005_8004);
        chk_seq("sparse_seq", base_idx, 16'h8000);

        // Overflow during drain, start ignored mid-fill.
        base_idx = out_q.size(); dc = done_cnt;
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        feed(16'h2000, 0, 128, 50);
        drain(1'b1, 1'b1, ok);
        chk("ovf_done_seen", 64'(ok), 64'(1));
        chk("ovf_set", 64'(ovf), 64'(1));
        chk_seq("ovf_seq", base_idx, 16'h2000);
        chk("ovf_done_cnt", 64'(done_cnt - dc), 64'(1));

        // New start clears ovf; reset after 70 samples.
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("ovf_cleared", 64'(ovf), 64'(0));
        feed(16'h5000, 0, 70, -1);
        reset = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk_reset_vals("rst_fill");
        reset = 1'b0;
        base_idx = out_q.size();
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        feed(16'h1000, 0, 128, -1);
        drain(1'b0, 1'b0, ok);
        chk("rfill_done_seen", 64'(ok), 64'(1));
        chk_seq("rfill_seq", base_idx, 16'h1000);

        // Reset after 40 output handshakes.
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        feed(16'h3000, 0, 128, -1);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b1);
            if (hs >= 40) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rdrain_reached40", 64'(ok), 64'(1));
        reset = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("rdrain_mvalid", 64'(bus.m_valid), 64'(0));
        chk("rdrain_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        base_idx = out_q.size();
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        feed(16'h6000, 0, 128, -1);
        drain(1'b1, 1'b0, ok);
        chk("rdrain_done_seen", 64'(ok), 64'(1));
        chk_seq("rdrain_seq", base_idx, 16'h6000);

        repeat (4) cyc(1'b0, 16'h0, 1'b0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdpb_capture_ctrl.md
# sdpb_capture_ctrl

Sequencing controller for the 64-bit-write / 16-bit-read simple dual-port block RAM (32 × 64 write side, 128 × 16 read side) used as the capture buffer. It packs an incoming 16-bit sample stream four-at-a-time into 64-bit RAM words, fills the whole buffer (128 samples), then drains it through a valid/ready 16-bit output stream in original sample order. It sits between the sample source and the readout/transmit logic, and drives every RAM control pin.

## Interface
- SAMPLES, 128: samples per capture. Fixed by RAM geometry; not to be changed.
- ADA_W, 5: RAM write address width (64-bit words).
- ADB_W, 7: RAM read address width (16-bit words).

Ports:
- clk  in  1  single clock, shared by both RAM ports.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a capture; honoured only in IDLE.
- s_valid  in  1  input sample strobe; no backpressure.
- s_data  in  16  input sample.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts.
- m_data  out  16  output sample; wired directly from ram_dout.
- m_last  out  1  high with the 128th output sample.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final output handshake.
- ovf  out  1  sticky; s_valid seen while not in FILL since the last start; cleared on start.
- ram_cea, ram_ada[4:0], ram_din[63:0]  out  write port; registered.
- ram_ceb  out  1  read enable; combinational.
- ram_adb  out  7  read address; from a register.
- ram_oce  out  1  constant 1.
- ram_reseta, ram_resetb  out  1  equal to reset.
- ram_dout  in  16  RAM read data, bypass mode, 1-cycle latency.

## Operation
- States:
  - IDLE: start → FILL. On entry, clear wr_word, lane, rd_ptr and ovf.
  - FILL: accept every s_valid.
  - DRAIN: read back the buffer.
  - DRAIN → IDLE at the 128th output handshake; done pulses that cycle +1.
- Packing:
  - A 2-bit lane counter selects the slot; samples k = 0..3 of a group go to bits [16k+15:16k]. Sample 0 is in the LSBs.
  - On the 4th sample: next edge registers ram_din = {s3,s2,s1,s0}, ram_ada = wr_word, ram_cea = 1 for one cycle. Then wr_word increments.
  - This layout makes read address 4·w+k return sample k of word w, so read order equals arrival order.
- FILL → DRAIN:
  - Taken in the same cycle the 32nd word write is issued; wr_word is 31 and wraps to 0.
  - The first read issues no earlier than the following edge, so there is no read-before-write hazard.
- Drain:
  - Condition: issue = DRAIN && rd_ptr < 128 && (!m_valid || m_ready).
  - When issue is true: ram_ceb = issue, ram_adb = rd_ptr[6:0], and rd_ptr increments (8-bit counter).
  - m_valid next = issue ? 1 : (m_valid && !m_ready).
  - While stalled, ceb = 0, so ram_dout and m_data hold stable.
  - m_last = m_valid && out_idx == 127. out_idx counts handshakes.
- Samples in IDLE/DRAIN are dropped and set ovf. A start while busy is ignored and does not clear ovf.
- reset in any state:
  - Returns to IDLE.
  - All outputs go to 0 next edge (ram_oce stays 1). A partial pack register is discarded.
  - RAM contents are undefined to the consumer; the next capture overwrites them fully.

## Timing
- Write: 4th sample accepted at edge N → ram_cea high during cycle N+1.
- Last write at edge T: state = DRAIN from T; first ram_ceb in cycle T+1; m_valid from T+2.
- With m_ready held high: one sample per cycle, 128 consecutive cycles, m_last on the final one, done the cycle after.
- Minimum FILL length is 128 cycles (continuous s_valid). Gaps in s_valid only extend FILL.
- Reset values:
  - state IDLE.
  - m_valid, m_last, busy, done, ovf, ram_cea, ram_ceb = 0.
  - ram_ada, ram_din, ram_adb = 0.

## Test plan
- Continuous ramp: start, then s_data = 0..127 on consecutive cycles, m_ready = 1.
  - Writes: word 0 ram_din = 0x0003_0002_0001_0000; word 31 = 0x007F_007E_007D_007C.
  - Output: 0..127 in order, m_last on 127, one done pulse, ovf = 0.
- Backpressure: same capture, m_ready toggled pseudo-randomly.
  - Output sequence identical; m_data stable whenever m_valid && !m_ready.
  - No sample duplicated or skipped.
- Sparse input: s_valid every 3rd cycle, data 0x8000 + i.
  - Packing correct; DRAIN entered only after the 128th sample.
- Overflow and ignored start: s_valid asserted throughout DRAIN, start pulsed mid-FILL.
  - ovf = 1; output unchanged; the capture is not restarted.
- Reset mid-FILL: reset after 70 samples.
  - Next cycle all outputs are at reset values.
  - A fresh capture of 0x1000 + i returns exactly that data.
- Reset mid-DRAIN: reset after 40 handshakes.
  - m_valid = 0 next edge; state IDLE.
  - A subsequent full capture passes.
